// File: rtl/test_harness_pkg.sv
// rtl/test_harness_pkg.sv - shared FSM type and Galois helpers for the registered test harness
package test_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Computed at full width; callers truncate back to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] galois_step(
        input logic [MAX_WIDTH-1:0] s,
        input logic [MAX_WIDTH-1:0] poly
    );
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

    function automatic int total_lat(input int in_stages, input int dut_lat, input int out_stages);
        return in_stages + dut_lat + out_stages;
    endfunction

endpackage

// File: rtl/test_harness_io_if.sv
// rtl/test_harness_io_if.sv - control and data bundle between the harness and its driver
interface test_harness_io_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             src_sel;
    logic             out_sel;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] dut_in;
    logic [WIDTH-1:0] dut_out;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;

    modport master (
        output start, src_sel, out_sel, in_data, dut_out,
        input  dut_in, out_data, busy, done
    );

    modport slave (
        input  start, src_sel, out_sel, in_data, dut_out,
        output dut_in, out_data, busy, done
    );
endinterface

// File: rtl/galois_reg.sv
// rtl/galois_reg.sv - Galois shift register with seed load, clear and xor-in; serves as LFSR or MISR
module galois_reg
    import test_harness_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'hB4BCD35C),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_seed,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] step;

    assign step = WIDTH'(galois_step(MAX_WIDTH'(q), MAX_WIDTH'(POLY)));

    always_ff @(posedge clk) begin
        if (rst || load_seed) begin
            q <= SEED;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= step ^ data;
        end
    end

endmodule

// File: rtl/test_harness_io.sv
// rtl/test_harness_io.sv - registered I/O wrapper with LFSR stimulus, MISR compaction and run control
module test_harness_io
    import test_harness_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               IN_STAGES  = 1,
    parameter int               OUT_STAGES = 1,
    parameter int               DUT_LAT    = 0,
    parameter int               RUN_CYCLES = 256,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(32'hB4BCD35C),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(1)
) (
    input  logic               clk,
    input  logic               rst,
    test_harness_io_if.slave   io
);

    localparam int TOTAL_LAT = total_lat(IN_STAGES, DUT_LAT, OUT_STAGES);
    localparam int CNT_W     = $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);

    if (SEED == '0) begin : g_bad_seed
        $error("test_harness_io: SEED must be nonzero");
    end
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("test_harness_io: WIDTH out of range");
    end
    if (IN_STAGES < 1 || OUT_STAGES < 1 || RUN_CYCLES < 1 || DUT_LAT < 0) begin : g_bad_depth
        $error("test_harness_io: stage/run parameters out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start_accept;
    logic             run;

    logic [WIDTH-1:0]     lfsr;
    logic [WIDTH-1:0]     sig;
    logic [WIDTH-1:0]     src;
    logic [WIDTH-1:0]     in_pipe  [IN_STAGES];
    logic [WIDTH-1:0]     out_pipe [OUT_STAGES];
    logic [WIDTH-1:0]     out_last;
    logic [WIDTH-1:0]     out_q;
    logic [TOTAL_LAT-1:0] tag_pipe;
    logic                 tag_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN ends once every tagged sample has left the tag pipe, i.e. the MISR took the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (io.start) state_nxt = ST_RUN;
            ST_RUN:           if (cnt == LAST_CNT) state_nxt = ST_DRAIN;
            ST_DRAIN:         if (tag_pipe == '0) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_accept = io.start && (state == ST_IDLE || state == ST_DONE);
        run          = (state == ST_RUN);
        io.busy      = (state == ST_RUN) || (state == ST_DRAIN);
        io.done      = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    galois_reg #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .en        (run),
        .load_seed (start_accept),
        .clear     (1'b0),
        .data      ('0),
        .q         (lfsr)
    );

    galois_reg #(.WIDTH(WIDTH), .POLY(POLY), .SEED('0)) u_misr (
        .clk       (clk),
        .rst       (rst),
        .en        (tag_last),
        .load_seed (1'b0),
        .clear     (start_accept),
        .data      (out_last),
        .q         (sig)
    );

    assign src = io.src_sel ? lfsr : io.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_STAGES; i++) in_pipe[i] <= '0;
        end else begin
            in_pipe[0] <= src;
            for (int i = 1; i < IN_STAGES; i++) in_pipe[i] <= in_pipe[i-1];
        end
    end

    assign io.dut_in = in_pipe[IN_STAGES-1];

    // One tag chain spans input stages, DUT latency and output stages so it lands with out_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[TOTAL_LAT-2:0], run};
        end
    end

    assign tag_last = tag_pipe[TOTAL_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_STAGES; i++) out_pipe[i] <= '0;
            out_q <= '0;
        end else begin
            out_pipe[0] <= io.dut_out;
            for (int i = 1; i < OUT_STAGES; i++) out_pipe[i] <= out_pipe[i-1];
            out_q <= io.out_sel ? sig : out_last;
        end
    end

    assign out_last    = out_pipe[OUT_STAGES-1];
    assign io.out_data = out_q;

endmodule
